mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single memory_block port between the instruction-fetch requester (IF) and the
//   load/store requester (DM) of the MIPS core. Each requester uses a req/ack handshake.
//   A multi-cycle FSM sequences every access with a programmable wait-state count.
//   Data accesses have priority. A starvation counter guarantees that fetch makes progress.
// PARAMETERS
//   ADDR_W        18  word address width, matching the memory_block address
//   DATA_W        32  data width
//   WAIT_CYCLES    0  extra access cycles the memory needs, 0..15
//   STARVE_LIMIT   4  consecutive DM wins while IF is waiting before IF is forced, 1..15
// PORTS
//   clock      in   1       rising-edge clock
//   reset_n    in   1       asynchronous reset, active low
//   if_req     in   1       fetch request (level)
//   if_addr    in   ADDR_W  fetch word address
//   if_ack     out  1       one-cycle pulse: fetch complete, if_rdata valid
//   if_rdata   out  DATA_W  registered fetch data
//   dm_req     in   1       data request (level)
//   dm_we      in   1       1 = store, 0 = load
//   dm_byte    in   1       byte operation (the byteOperations signal)
//   dm_addr    in   ADDR_W  data word address
//   dm_wdata   in   DATA_W  store data
//   dm_ack     out  1       one-cycle pulse: data access complete
//   dm_rdata   out  DATA_W  registered load data
//   mem_addr   out  ADDR_W  to memory_block
//   mem_wdata  out  DATA_W  to memory_block
//   mem_rd     out  1       memRead strobe
//   mem_wr     out  1       memWrite strobe
//   mem_byte   out  1       byte-operation select
//   mem_rdata  in   DATA_W  from memory_block (combinational read)
//   busy       out  1       1 when the FSM is not in IDLE
// BEHAVIOUR
//   - Reset (asynchronous, when reset_n = 0), applied immediately:
//       state = IDLE; every ack, strobe and busy = 0; rdata registers = 0; mem_addr, mem_wdata = 0;
//       starve_cnt = 0; wait_cnt = 0.
//       An in-flight access is abandoned, no ack is issued, and mem_wr drops at once.
//   - FSM states: IDLE -> ACCESS -> ACK -> IDLE.
//   - IDLE: the arbitration decision is made at the rising edge.
//       Only DM requesting: grant DM.
//       Only IF requesting: grant IF.
//       Both requesting: grant DM if starve_cnt < STARVE_LIMIT, else grant IF.
//       Neither requesting: stay in IDLE.
//   - On a grant:
//       Register owner, mem_addr, mem_wdata, mem_byte, mem_rd and mem_wr.
//       IF grant: mem_rd = 1, mem_wr = 0, mem_byte = 0.
//       DM grant: mem_rd = ~dm_we, mem_wr = dm_we, mem_byte = dm_byte.
//       Load wait_cnt = WAIT_CYCLES.
//   - ACCESS: strobes are held for WAIT_CYCLES+1 cycles; wait_cnt decrements each cycle.
//       When wait_cnt == 0, go to ACK on the next edge.
//       On that edge, the owner's rdata register captures mem_rdata; this is a read only, a store leaves dm_rdata unchanged.
//       Strobes clear on that edge.
//   - ACK: pulse the owner's ack for exactly one cycle; busy = 1; return to IDLE.
//       No arbitration takes place in ACK.
//   - Latency: request seen in IDLE at cycle N gives ack in cycle N+2+WAIT_CYCLES.
//       The earliest back-to-back grant is at the edge ending cycle N+3+WAIT_CYCLES.
//   - Handshake: the requester holds req, addr, wdata, we and byte stable until its ack.
//       A registered requester drops req at the edge that ends the ack cycle.
//       Inputs are sampled only in IDLE; changes during ACCESS/ACK are ignored.
//   - starve_cnt is a 4-bit saturating counter:
//       +1 on each DM grant made while if_req = 1;
//       cleared on each IF grant;
//       unchanged on a DM grant made while if_req = 0.
//   - Each ack is never asserted without a matching grant. if_ack and dm_ack are never high together.
// CONFIGURATION
//   MEM_ARB_PERF_EN defined:
//     Adds output ports perf_if_cnt [15:0], perf_dm_cnt [15:0] and perf_conflict_cnt [15:0].
//     All three are saturating counters, cleared on reset.
//     perf_if_cnt: incremented on each IF grant.
//     perf_dm_cnt: incremented on each DM grant.
//     perf_conflict_cnt: incremented for every IDLE cycle with if_req & dm_req.
//   MEM_ARB_PERF_EN not defined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//   1. Reset: hold reset_n = 0 mid-ACCESS of a store -> mem_wr = 0 at once, no dm_ack, state IDLE, rdata = 0.
//   2. Lone fetch, WAIT_CYCLES = 0: if_req = 1 at cycle 0 with if_addr = 5, mem_rdata = 32'hDEADBEEF
//      -> mem_rd = 1 in cycle 1, if_ack = 1 in cycle 2, if_rdata = 32'hDEADBEEF.
//   3. Store: dm_req = 1, dm_we = 1, dm_byte = 1, dm_addr = 18'h10, dm_wdata = 32'h000000AB
//      -> mem_wr = 1 and mem_byte = 1 for 1 cycle; dm_ack follows; dm_rdata unchanged.
//   4. Conflict: if_req and dm_req both held high for 6 transactions, STARVE_LIMIT = 4
//      -> grant order is DM, DM, DM, DM, IF, DM.
//   5. Wait states, WAIT_CYCLES = 3: one load
//      -> mem_rd high for exactly 4 cycles; dm_ack in cycle 5 after the request.
//   6. MEM_ARB_PERF_EN: the scenario 4 sequence -> perf_dm_cnt = 5, perf_if_cnt = 1, perf_conflict_cnt = 6.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory_block port between fetch (IF) and load/store (DM) with wait states and anti-starvation.
// Optional MEM_ARB_PERF_EN adds saturating grant/conflict counters.
module mem_port_arbiter #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 32,
  parameter int WAIT_CYCLES = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic              dm_byte,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              mem_byte,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [15:0]       perf_if_cnt,
  output logic [15:0]       perf_dm_cnt,
  output logic [15:0]       perf_conflict_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
  localparam logic [3:0] WAIT = 4'(WAIT_CYCLES);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  state_t state, state_nxt;
  logic owner;
  logic [3:0] wait_cnt, starve_cnt;
  logic grant_dm, grant_if, grant;
  always_comb begin
    grant_dm = dm_req & (~if_req | (starve_cnt < LIMIT));
    grant_if = if_req & ~grant_dm;
    grant = (state == IDLE) & (grant_dm | grant_if);
    state_nxt = (state == IDLE) ? (grant ? ACCESS : IDLE) :
                (state == ACCESS) ? ((wait_cnt == 4'd0) ? ACK : ACCESS) : IDLE;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      owner <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      mem_byte <= 1'b0;
      wait_cnt <= '0;
      starve_cnt <= '0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else if (grant) begin
      owner <= grant_dm;
      mem_addr <= grant_dm ? dm_addr : if_addr;
      mem_wdata <= grant_dm ? dm_wdata : '0;
      mem_rd <= grant_if | ~dm_we;
      mem_wr <= grant_dm & dm_we;
      mem_byte <= grant_dm & dm_byte;
      wait_cnt <= WAIT;
      starve_cnt <= grant_if ? 4'd0 : (if_req && starve_cnt != 4'hF) ? starve_cnt + 4'd1 : starve_cnt;
    end else if (state == ACCESS) begin
      if (wait_cnt == 4'd0) begin
        mem_rd <= 1'b0;
        mem_wr <= 1'b0;
        mem_byte <= 1'b0;
        if (mem_rd && owner) dm_rdata <= mem_rdata;
        if (mem_rd && !owner) if_rdata <= mem_rdata;
      end else wait_cnt <= wait_cnt - 4'd1;
    end
  end
`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_if_cnt <= '0;
      perf_dm_cnt <= '0;
      perf_conflict_cnt <= '0;
    end else begin
      if (grant && grant_if && perf_if_cnt != 16'hFFFF) perf_if_cnt <= perf_if_cnt + 16'd1;
      if (grant && grant_dm && perf_dm_cnt != 16'hFFFF) perf_dm_cnt <= perf_dm_cnt + 16'd1;
      if (state == IDLE && if_req && dm_req && perf_conflict_cnt != 16'hFFFF)
        perf_conflict_cnt <= perf_conflict_cnt + 16'd1;
    end
  end
`endif
  assign if_ack = (state == ACK) & ~owner;
  assign dm_ack = (state == ACK) & owner;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter (WAIT_CYCLES 0 and 3 instances).
module tb_mem_port_arbiter;
  localparam int AW = 18;
  localparam int DW = 32;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic if_req, dm_req, dm_we, dm_byte, if_ack, dm_ack, mem_rd, mem_wr, mem_byte, busy;
  logic [AW-1:0] if_addr, dm_addr, mem_addr;
  logic [DW-1:0] dm_wdata, mem_rdata, if_rdata, dm_rdata, mem_wdata;
  logic d3_if_req, d3_dm_req, d3_dm_we, d3_dm_byte, d3_if_ack, d3_dm_ack, d3_mem_rd, d3_mem_wr, d3_mem_byte, d3_busy;
  logic [AW-1:0] d3_if_addr, d3_dm_addr, d3_mem_addr;
  logic [DW-1:0] d3_dm_wdata, d3_mem_rdata, d3_if_rdata, d3_dm_rdata, d3_mem_wdata;
`ifdef MEM_ARB_PERF_EN
  logic [15:0] perf_if_cnt, perf_dm_cnt, perf_conflict_cnt;
  logic [15:0] d3_perf_if_cnt, d3_perf_dm_cnt, d3_perf_conflict_cnt;
`endif
  typedef struct {logic dm; logic [31:0] rdata; int lat;} exp_t;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  always #5 clock = ~clock;
  mem_port_arbiter #(.WAIT_CYCLES(0), .STARVE_LIMIT(4)) dut0 (
    .clock(clock), .reset_n(reset_n), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .if_rdata(if_rdata), .dm_req(dm_req), .dm_we(dm_we), .dm_byte(dm_byte), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_byte(mem_byte),
    .mem_rdata(mem_rdata), .busy(busy)
`ifdef MEM_ARB_PERF_EN
    , .perf_if_cnt(perf_if_cnt), .perf_dm_cnt(perf_dm_cnt), .perf_conflict_cnt(perf_conflict_cnt)
`endif
  );
  mem_port_arbiter #(.WAIT_CYCLES(3), .STARVE_LIMIT(4)) dut3 (
    .clock(clock), .reset_n(reset_n), .if_req(d3_if_req), .if_addr(d3_if_addr), .if_ack(d3_if_ack),
    .if_rdata(d3_if_rdata), .dm_req(d3_dm_req), .dm_we(d3_dm_we), .dm_byte(d3_dm_byte),
    .dm_addr(d3_dm_addr), .dm_wdata(d3_dm_wdata), .dm_ack(d3_dm_ack), .dm_rdata(d3_dm_rdata),
    .mem_addr(d3_mem_addr), .mem_wdata(d3_mem_wdata), .mem_rd(d3_mem_rd), .mem_wr(d3_mem_wr),
    .mem_byte(d3_mem_byte), .mem_rdata(d3_mem_rdata), .busy(d3_busy)
`ifdef MEM_ARB_PERF_EN
    , .perf_if_cnt(d3_perf_if_cnt), .perf_dm_cnt(d3_perf_dm_cnt), .perf_conflict_cnt(d3_perf_conflict_cnt)
`endif
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_ack(input int start, output logic got_dm, output int cyc);
    got_dm = 1'b0;
    cyc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (if_ack || dm_ack) begin
        got_dm = dm_ack;
        cyc = start + i;
        chk("ack_exclusive", {63'd0, if_ack & dm_ack}, 64'd0);
        break;
      end
    end
  endtask
  task automatic score(input string tag, input logic got_dm, input int cyc, input logic [31:0] rd);
    exp_t e;
    e = sb.pop_front();
    chk({tag, "_who"}, {63'd0, got_dm}, {63'd0, e.dm});
    chk({tag, "_lat"}, 64'(cyc), 64'(e.lat));
    chk({tag, "_rdata"}, {32'd0, rd}, {32'd0, e.rdata});
  endtask
  initial begin
    #100000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end
  initial begin
    logic got;
    int cyc, rd_cnt, ack_at;
    {if_req, dm_req, dm_we, dm_byte} = '0;
    {if_addr, dm_addr, dm_wdata, mem_rdata} = '0;
    {d3_if_req, d3_dm_req, d3_dm_we, d3_dm_byte} = '0;
    {d3_if_addr, d3_dm_addr, d3_dm_wdata, d3_mem_rdata} = '0;
    repeat (2) @(negedge clock);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_strobes", {61'd0, mem_rd, mem_wr, mem_byte}, 64'd0);
    chk("rst_acks", {62'd0, if_ack, dm_ack}, 64'd0);
    chk("rst_rdata", {if_rdata, dm_rdata}, 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_d3_busy", {63'd0, d3_busy}, 64'd0);
    reset_n = 1'b1;
    // lone fetch
    @(posedge clock); #1;
    mem_rdata = 32'hDEADBEEF;
    if_addr = 18'd5;
    if_req = 1'b1;
    sb.push_back('{dm: 1'b0, rdata: 32'hDEADBEEF, lat: 2});
    @(negedge clock);
    chk("fetch_c0_rd", {63'd0, mem_rd}, 64'd0);
    @(negedge clock);
    chk("fetch_c1_rd", {63'd0, mem_rd}, 64'd1);
    chk("fetch_c1_addr", 64'(mem_addr), 64'd5);
    chk("fetch_c1_busy", {63'd0, busy}, 64'd1);
    wait_ack(2, got, cyc);
    score("fetch", got, cyc, got ? dm_rdata : if_rdata);
    @(posedge clock); #1;
    if_req = 1'b0;
    @(negedge clock);
    chk("fetch_ack_pulse", {63'd0, if_ack}, 64'd0);
    chk("fetch_idle", {63'd0, busy}, 64'd0);
    // byte store
    @(posedge clock); #1;
    mem_rdata = 32'h12345678;
    {dm_we, dm_byte} = 2'b11;
    dm_addr = 18'h10;
    dm_wdata = 32'h000000AB;
    dm_req = 1'b1;
    sb.push_back('{dm: 1'b1, rdata: 32'h0, lat: 2});
    @(negedge clock);
    @(negedge clock);
    chk("store_strobes", {61'd0, mem_rd, mem_wr, mem_byte}, 64'b011);
    chk("store_addr", 64'(mem_addr), 64'h10);
    chk("store_wdata", 64'(mem_wdata), 64'hAB);
    wait_ack(2, got, cyc);
    chk("store_wr_cleared", {63'd0, mem_wr}, 64'd0);
    score("store", got, cyc, got ? dm_rdata : if_rdata);
    @(posedge clock); #1;
    dm_req = 1'b0;
    // reset during a store's access cycle
    @(posedge clock); #1;
    dm_addr = 18'h20;
    dm_wdata = 32'h55;
    dm_req = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("rstmid_wr_before", {63'd0, mem_wr}, 64'd1);
    reset_n = 1'b0;
    #1;
    chk("rstmid_wr", {63'd0, mem_wr}, 64'd0);
    chk("rstmid_busy", {63'd0, busy}, 64'd0);
    chk("rstmid_rdata", {if_rdata, dm_rdata}, 64'd0);
    chk("rstmid_addr", 64'(mem_addr), 64'd0);
    @(negedge clock);
    chk("rstmid_no_ack", {62'd0, if_ack, dm_ack}, 64'd0);
    dm_req = 1'b0;
    reset_n = 1'b1;
    // sustained conflict: starvation limit forces one fetch after four data grants
    @(posedge clock); #1;
    mem_rdata = 32'hCAFE0000;
    {dm_we, dm_byte} = 2'b00;
    if_req = 1'b1;
    dm_req = 1'b1;
    for (int k = 0; k < 6; k++) sb.push_back('{dm: (k != 4), rdata: 32'hCAFE0000, lat: 2});
    for (int k = 0; k < 6; k++) begin
      wait_ack(0, got, cyc);
      score($sformatf("conflict%0d", k), got, cyc, got ? dm_rdata : if_rdata);
    end
    @(posedge clock); #1;
    if_req = 1'b0;
    dm_req = 1'b0;
    @(negedge clock);
`ifdef MEM_ARB_PERF_EN
    chk("perf_dm", 64'(perf_dm_cnt), 64'd5);
    chk("perf_if", 64'(perf_if_cnt), 64'd1);
    chk("perf_conflict", 64'(perf_conflict_cnt), 64'd6);
`endif
    chk("conflict_idle", {63'd0, busy}, 64'd0);
    // wait-state load on the WAIT_CYCLES=3 instance
    @(posedge clock); #1;
    d3_mem_rdata = 32'h5A5A1234;
    d3_dm_addr = 18'd7;
    d3_dm_req = 1'b1;
    sb.push_back('{dm: 1'b1, rdata: 32'h5A5A1234, lat: 5});
    rd_cnt = 0;
    ack_at = -1;
    got = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      rd_cnt += int'(d3_mem_rd);
      if (d3_dm_ack && ack_at < 0) begin
        ack_at = i;
        got = 1'b1;
      end
    end
    score("ws_load", got, ack_at, d3_dm_rdata);
    chk("ws_rd_cycles", 64'(rd_cnt), 64'd4);
    @(posedge clock); #1;
    d3_dm_req = 1'b0;
    @(negedge clock);
    chk("ws_idle", {62'd0, d3_busy, d3_mem_rd}, 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
